// File: rtl/fifo_reader_if.sv
// Bundles the FIFO read port, the burst control/status signals and the output stream.
// master = the reader; slave = the surrounding FIFO, controller and consumer.
interface fifo_reader_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int LEN_W      = 5
);
    logic                  empty;
    logic [FIFO_WIDTH-1:0] dout_b;
    logic                  ren_b;
    logic                  start;
    logic [LEN_W-1:0]      burst_len;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  busy;
    logic                  done;
    logic [15:0]           rd_count;

    modport master (
        input  empty, dout_b, start, burst_len, m_ready,
        output ren_b, m_data, m_valid, busy, done, rd_count
    );

    modport slave (
        output empty, dout_b, start, burst_len, m_ready,
        input  ren_b, m_data, m_valid, busy, done, rd_count
    );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len words from a registered-read FIFO into a
// 2-entry skid buffer and presents them on a valid/ready stream.
module fifo_reader #(
    parameter int FIFO_WIDTH = 8,
    parameter int LEN_W      = 5
) (
    input  logic          clk_b,
    input  logic          rst,
    fifo_reader_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] mem_q [2];
    logic [FIFO_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic                  pop;
    logic                  ren;

    always_comb begin
        pop = (cnt_q != 2'd0) && bus.m_ready;
        // Issue only if the word can still land: occupancy after this edge plus the new read fits in 2.
        ren = (state_q == ACTIVE) && !bus.empty && (remaining_q != '0) &&
              (({1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

        state_d     = state_q;
        remaining_d = remaining_q;
        inflight_d  = ren;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_count_d  = rd_count_q + {15'd0, pop};
        done_d      = 1'b0;

        if (inflight_q) begin
            mem_d[wr_ptr_q] = bus.dout_b;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (ren) begin
            remaining_d = remaining_q - LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.burst_len != '0)) begin
                    state_d     = ACTIVE;
                    remaining_d = bus.burst_len;
                end
            end
            ACTIVE: begin
                if (ren && (remaining_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_b or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            done_q      <= 1'b0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            rd_count_q  <= rd_count_d;
        end
    end

    assign bus.ren_b    = ren;
    assign bus.m_valid  = (cnt_q != 2'd0);
    assign bus.m_data   = mem_q[rd_ptr_q];
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.rd_count = rd_count_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a registered-read FIFO model feeds the DUT, a negedge
// monitor captures the output stream, and directed sequences check each scenario.
module tb_fifo_reader;
    logic clk_b = 1'b0;
    logic rst;

    fifo_reader_if #(.FIFO_WIDTH(8), .LEN_W(5)) bus ();
    fifo_reader #(.FIFO_WIDTH(8), .LEN_W(5)) dut (.clk_b(clk_b), .rst(rst), .bus(bus));

    always #5 clk_b = ~clk_b;

    int tests = 0;
    int fails = 0;

    // FIFO model with registered read
    logic [7:0] fifo_mem [64];
    logic [5:0] fifo_wr = 6'd0;
    logic [5:0] fifo_rd = 6'd0;
    assign bus.empty = (fifo_wr == fifo_rd);
    always @(posedge clk_b) begin
        if (bus.ren_b && !bus.empty) begin
            bus.dout_b <= fifo_mem[fifo_rd];
            fifo_rd    <= fifo_rd + 6'd1;
        end
    end

    // Output stream monitor
    logic [7:0] cap [64];
    logic [5:0] ncap = 6'd0;
    int issued = 0, xfers = 0, done_cnt = 0;
    int ren_viol = 0, occ_viol = 0, stab_viol = 0;
    logic stall_q = 1'b0;
    logic [7:0] stall_data = 8'd0;
    always @(negedge clk_b) begin
        if (!rst) begin
            issued  <= 0;
            xfers   <= 0;
            stall_q <= 1'b0;
        end else begin
            if (bus.ren_b && bus.empty) ren_viol <= ren_viol + 1;
            if (stall_q && !(bus.m_valid && bus.m_data == stall_data)) stab_viol <= stab_viol + 1;
            stall_q    <= bus.m_valid && !bus.m_ready;
            stall_data <= bus.m_data;
            issued     <= issued + (bus.ren_b ? 1 : 0);
            if (bus.m_valid && bus.m_ready) begin
                cap[ncap] <= bus.m_data;
                ncap      <= ncap + 6'd1;
                xfers     <= xfers + 1;
            end
            if ((issued + (bus.ren_b ? 1 : 0)) - (xfers + ((bus.m_valid && bus.m_ready) ? 1 : 0)) > 2)
                occ_viol <= occ_viol + 1;
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        fifo_mem[fifo_wr] = v;
        fifo_wr = fifo_wr + 6'd1;
    endtask

    task automatic go(input logic [4:0] len);
        bus.start     = 1'b1;
        bus.burst_len = len;
        tick();
        bus.start     = 1'b0;
        bus.burst_len = 5'd0;
    endtask

    task automatic wait_done(input int d0, input int lim, input string name);
        for (int c = 0; c < lim && done_cnt == d0; c++) tick();
        check(name, done_cnt, d0 + 1);
    endtask

    function automatic logic [31:0] out_vec();
        return {4'd0, bus.ren_b, bus.m_valid, bus.m_data, bus.busy, bus.done, bus.rd_count};
    endfunction

    typedef struct {
        logic       start;
        logic [4:0] len;
        logic       ready;
        logic       ren;
        logic       valid;
        logic       chk_data;
        logic [7:0] data;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] b;
        int d0;

        // Cycle-by-cycle burst of 4 over words 5,1,6,3; starts in ACTIVE/DRAIN are ignored
        vecs[0] = '{1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.burst_len = 5'd0;
        bus.m_ready   = 1'b0;
        tick();
        tick();
        check("reset_outputs", out_vec(), 32'd0);

        push(8'd5); push(8'd1); push(8'd6); push(8'd3);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            bus.start     = vecs[i].start;
            bus.burst_len = vecs[i].len;
            bus.m_ready   = vecs[i].ready;
            #3;
            check($sformatf("vec%0d", i),
                  {27'd0, bus.ren_b, bus.m_valid, (vecs[i].chk_data ? bus.m_data : 8'd0), bus.busy, bus.done},
                  {27'd0, vecs[i].ren, vecs[i].valid, vecs[i].data, vecs[i].busy, vecs[i].done});
            tick();
        end
        bus.start = 1'b0;
        bus.burst_len = 5'd0;
        check("b_rd_count", bus.rd_count, 32'd4);
        check("b_done_cnt", done_cnt, 32'd1);
        check("b_stream", {cap[0], cap[1], cap[2], cap[3]}, {8'd5, 8'd1, 8'd6, 8'd3});

        // Backpressure: m_ready toggling every cycle
        b = ncap; d0 = done_cnt;
        push(8'd10); push(8'd11); push(8'd12); push(8'd13);
        bus.m_ready = 1'b1;
        go(5'd4);
        for (int c = 0; c < 60 && done_cnt == d0; c++) begin
            bus.m_ready = ~bus.m_ready;
            tick();
        end
        check("c_done", done_cnt, d0 + 1);
        check("c_count", ncap - b, 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("c_word%0d", k), cap[b + 6'(k)], 32'(10 + k));
        check("c_rd_count", bus.rd_count, 32'd8);
        bus.m_ready = 1'b1;

        // FIFO runs dry mid-burst, then refills
        b = ncap; d0 = done_cnt;
        push(8'd20); push(8'd21);
        go(5'd5);
        repeat (10) tick();
        check("d_stalled", {bus.busy, bus.ren_b}, 2'b10);
        check("d_no_done", done_cnt, d0);
        check("d_partial", ncap - b, 32'd2);
        push(8'd22); push(8'd23); push(8'd24);
        wait_done(d0, 40, "d_done");
        check("d_count", ncap - b, 32'd5);
        for (int k = 0; k < 5; k++)
            check($sformatf("d_word%0d", k), cap[b + 6'(k)], 32'(20 + k));
        check("d_rd_count", bus.rd_count, 32'd13);

        // Reset after two of six words delivered
        b = ncap;
        push(8'd30); push(8'd31); push(8'd32); push(8'd33); push(8'd34); push(8'd35);
        go(5'd6);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_b);
            if (ncap == b + 6'd2) break;
        end
        #1;
        check("e_two_delivered", ncap - b, 32'd2);
        rst = 1'b0;
        #1;
        check("e_reset_outputs", out_vec(), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("e_idle_after_release", {bus.busy, bus.m_valid, bus.ren_b}, 3'b000);
        b = ncap; d0 = done_cnt;
        go(5'd1);
        wait_done(d0, 30, "e_done");
        check("e_count", ncap - b, 32'd1);
        check("e_word", cap[b], 32'd34);
        check("e_rd_count", bus.rd_count, 32'd1);

        // rd_count wrap, then a zero-length start is ignored
        force dut.rd_count_q = 16'hFFFE;
        tick();
        release dut.rd_count_q;
        tick();
        check("f_preset", bus.rd_count, 32'hFFFE);
        d0 = done_cnt;
        push(8'd40); push(8'd41); push(8'd42);
        go(5'd3);
        wait_done(d0, 30, "f_done");
        check("f_rd_count_wrap", bus.rd_count, 32'd1);
        go(5'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("f_zero_len%0d", k), {bus.busy, bus.ren_b}, 2'b00);
            tick();
        end

        check("ren_while_empty", ren_viol, 32'd0);
        check("occupancy_over_2", occ_viol, 32'd0);
        check("stall_stability", stab_viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter FIFO_WIDTH, default 8: data word width in bits.
REQ-002 Parameter LEN_W, default 5: width of burst_len; maximum burst is 2^LEN_W - 1 words.
REQ-003 clk_b  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 empty  input  1  FIFO empty flag, synchronous to clk_b.
REQ-006 dout_b  input  FIFO_WIDTH  FIFO read data; registered read, valid in the cycle after the edge that sampled ren_b=1 with empty=0.
REQ-007 ren_b  output  1  FIFO read enable.
REQ-008 start  input  1  one-cycle request to begin a burst.
REQ-009 burst_len  input  LEN_W  number of words in the burst, sampled with start.
REQ-010 m_data  output  FIFO_WIDTH  output stream data.
REQ-011 m_valid  output  1  output stream valid.
REQ-012 m_ready  input  1  output stream ready from the downstream consumer.
REQ-013 busy  output  1  high while not in IDLE.
REQ-014 done  output  1  one-cycle pulse when a burst completes.
REQ-015 rd_count  output  16  total words delivered on the output stream since reset.

Function
REQ-016 The FSM shall have three states: IDLE, ACTIVE and DRAIN.
REQ-017 IDLE->ACTIVE when start=1 and burst_len!=0: latch burst_len into a remaining-issue counter.
REQ-018 In IDLE, start=1 with burst_len=0 shall be ignored.
REQ-019 start shall be ignored in ACTIVE and DRAIN.
REQ-020 ren_b shall be combinational and high only when all hold: state=ACTIVE, empty=0, remaining!=0, and (buffer occupancy + reads in flight - output pop this cycle) < 2.
REQ-021 Each cycle with ren_b=1 shall decrement remaining by 1.
REQ-022 Each cycle with ren_b=1 shall mark one read in flight.
REQ-023 The word returned on dout_b shall be written into a 2-entry in-order buffer at the following edge.
REQ-024 ren_b shall never be high while empty=1; underflow is structurally impossible.
REQ-025 ACTIVE->DRAIN at the edge where remaining reaches 0.
REQ-026 DRAIN->IDLE when the buffer is empty and no read is in flight.
REQ-027 done shall be high for exactly the one cycle following the DRAIN->IDLE edge.
REQ-028 m_valid = buffer not empty, and m_data = buffer head.
REQ-029 A transfer occurs when m_valid=1 and m_ready=1; on a transfer the head is popped.
REQ-030 While m_valid=1 and m_ready=0, m_data and m_valid shall hold stable.
REQ-031 A buffer write and a pop in the same cycle shall both take effect, with occupancy unchanged.
REQ-032 Latency: start sampled at edge E0 -> ren_b may assert after E0 -> m_valid first high after E2.
REQ-033 Throughput: with empty=0 and m_ready=1 held, m_valid shall stay high every cycle from the first word to the last word of the burst.
REQ-034 Empty mid-burst: when empty=1 during ACTIVE, ren_b=0 and the FSM stays in ACTIVE; reading resumes in the cycle empty deasserts, with no word lost or duplicated.
REQ-035 rd_count shall increment by 1 on each transfer and wrap from 16'hFFFF to 0.
REQ-036 rd_count shall not be cleared by start.

Reset
REQ-037 rst=0 shall immediately force: state IDLE, ren_b=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, buffer empty, in-flight cleared, remaining=0.
REQ-038 A reset asserted mid-burst shall discard buffered and in-flight words.
REQ-039 After reset, data arriving on dout_b from a pre-reset read shall be ignored.
REQ-040 Release of reset shall be treated as synchronous to clk_b; the block stays in IDLE until the next start.

Verification
REQ-041 FIFO preloaded with 5,1,6,3; start with burst_len=4, m_ready=1 -> ren_b high for 4 consecutive cycles; m_data 5,1,6,3 on consecutive cycles; done pulses once; rd_count=4.
REQ-042 burst_len=4, m_ready toggling 1,0,1,0 -> no word lost or duplicated; m_data stable while stalled; ren_b never raises occupancy above 2.
REQ-043 FIFO holding 2 words, burst_len=5 -> after 2 reads FSM stays in ACTIVE with ren_b=0; writing 3 more words completes the burst; done pulses; rd_count +5.
REQ-044 ren_b shall never be asserted while empty=1, checked by an assertion across all scenarios.
REQ-045 rst=0 asserted after 2 of 6 words delivered -> all outputs at reset values the same cycle; a new start with burst_len=1 after release delivers the next FIFO word.
REQ-046 rd_count forced to 16'hFFFE then 3 words delivered -> rd_count=1; start with burst_len=0 -> busy stays 0.
